// File: rtl/dmi_jtag_access_ctrl.sv
// DMI access sequencer in the TCK domain: owns the DMIACCESS data register, decodes scanned
// requests into one valid/ready DMI transaction each and reports sticky status on capture.
module dmi_jtag_access_ctrl #(
  parameter int unsigned AddrWidth = 7
) (
  input  logic                 tck_i,
  input  logic                 trst_ni,
  input  logic                 test_logic_reset_i,
  input  logic                 capture_dr_i,
  input  logic                 shift_dr_i,
  input  logic                 update_dr_i,
  input  logic                 dmi_access_i,
  input  logic                 dmi_reset_i,
  input  logic                 dmi_tdi_i,
  output logic                 dmi_tdo_o,
  output logic [1:0]           dmi_error_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [AddrWidth-1:0] dmi_req_addr_o,
  output logic [31:0]          dmi_req_data_o,
  output logic [1:0]           dmi_req_op_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [31:0]          dmi_resp_data_i,
  input  logic [1:0]           dmi_resp_resp_i
);

  localparam int unsigned DrWidth = AddrWidth + 34;

  localparam logic [1:0] OpRead   = 2'd1;
  localparam logic [1:0] OpWrite  = 2'd2;
  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrFail  = 2'd2;
  localparam logic [1:0] ErrBusy  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWaitReadValid,
    StWrite,
    StWaitWriteValid
  } state_e;

  state_e               state_q, state_d;
  logic [DrWidth-1:0]   dr_q, dr_d;
  logic [AddrWidth-1:0] address_q, address_d;
  logic [31:0]          data_q, data_d;
  logic [1:0]           error_q, error_d;
  logic                 discard_q, discard_d;

  logic capture, shift, update, busy, resp_hs, keep_resp;

  assign capture   = capture_dr_i & dmi_access_i;
  assign shift     = shift_dr_i & dmi_access_i;
  assign update    = update_dr_i & dmi_access_i;
  assign busy      = (state_q != StIdle);
  assign resp_hs   = dmi_resp_valid_i & dmi_resp_ready_o;
  // A transaction in flight across Test-Logic-Reset still completes, but its result is dropped.
  assign keep_resp = ~discard_q & ~test_logic_reset_i;

  // State register
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (update && !test_logic_reset_i && (error_q == ErrNone)) begin
          if (dr_q[1:0] == OpRead) begin
            state_d = StRead;
          end else if (dr_q[1:0] == OpWrite) begin
            state_d = StWrite;
          end
        end
      end
      StRead: begin
        if (dmi_req_ready_i) state_d = StWaitReadValid;
      end
      StWaitReadValid: begin
        if (dmi_resp_valid_i) state_d = StIdle;
      end
      StWrite: begin
        if (dmi_req_ready_i) state_d = StWaitWriteValid;
      end
      StWaitWriteValid: begin
        if (dmi_resp_valid_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    dmi_req_valid_o  = 1'b0;
    dmi_req_op_o     = 2'd0;
    dmi_resp_ready_o = 1'b0;
    unique case (state_q)
      StRead: begin
        dmi_req_valid_o = 1'b1;
        dmi_req_op_o    = OpRead;
      end
      StWrite: begin
        dmi_req_valid_o = 1'b1;
        dmi_req_op_o    = OpWrite;
      end
      StWaitReadValid, StWaitWriteValid: dmi_resp_ready_o = 1'b1;
      default: ;
    endcase
  end

  assign dmi_req_addr_o = address_q;
  assign dmi_req_data_o = data_q;
  assign dmi_tdo_o      = dr_q[0];
  assign dmi_error_o    = error_q;

  // Datapath next-state
  always_comb begin
    dr_d      = dr_q;
    address_d = address_q;
    data_d    = data_q;
    error_d   = error_q;

    if (dmi_reset_i) error_d = ErrNone;

    if (resp_hs && keep_resp) begin
      if (dmi_resp_resp_i != ErrNone) begin
        error_d = (dmi_resp_resp_i == 2'd1) ? ErrFail : dmi_resp_resp_i;
      end
      if (state_q == StWaitReadValid) data_d = dmi_resp_data_i;
    end

    // Any DR access while a transaction is outstanding flags busy; this wins over dmireset.
    if ((capture || update) && busy) error_d = ErrBusy;

    if (update && !busy && (error_q == ErrNone)) begin
      address_d = dr_q[DrWidth-1:34];
      data_d    = dr_q[33:2];
    end

    if (capture) begin
      dr_d = {address_q, data_q, error_d};
    end else if (shift) begin
      dr_d = {dmi_tdi_i, dr_q[DrWidth-1:1]};
    end

    if (test_logic_reset_i) begin
      dr_d      = '0;
      address_d = '0;
      data_d    = '0;
      error_d   = ErrNone;
    end
  end

  assign discard_d = (state_d != StIdle) && (discard_q || test_logic_reset_i);

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      dr_q      <= '0;
      address_q <= '0;
      data_q    <= '0;
      error_q   <= ErrNone;
      discard_q <= 1'b0;
    end else begin
      dr_q      <= dr_d;
      address_q <= address_d;
      data_q    <= data_d;
      error_q   <= error_d;
      discard_q <= discard_d;
    end
  end

endmodule
